nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001: Parameter NIBBLES, default 4, SHALL set the operand width W = 4*NIBBLES; legal range 2..8.
REQ-002: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003: rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004: in_valid  input  1  SHALL indicate that a, b and cin hold a new operation.
REQ-005: in_ready  output  1  SHALL indicate that the block can accept an operation.
REQ-006: a  input  W  SHALL be operand A (unsigned or two's complement).
REQ-007: b  input  W  SHALL be operand B.
REQ-008: cin  input  1  SHALL be the carry-in to nibble 0.
REQ-009: out_valid  output  1  SHALL indicate that sum, cout and ovf are valid.
REQ-010: out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011: sum  output  W  SHALL be the registered result a+b+cin mod 2^W.
REQ-012: cout  output  1  SHALL be the carry out of bit W-1.
REQ-013: ovf  output  1  SHALL be the two's-complement overflow flag.

Function
REQ-014: The block SHALL compute the sum one nibble per cycle through a single instance of the existing 4-bit ripple-carry stage rca_4bit (ports x, y, ci, s, co); no other adder is permitted.
REQ-015: The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016: in_ready SHALL be 1 only in IDLE and only while rst is 0; out_valid SHALL be 1 only in DONE.
REQ-017: IDLE with in_valid=1 at an edge SHALL capture a, b and cin into operand/carry registers, clear nibble index idx to 0, and move to ADD; with in_valid=0 it SHALL stay in IDLE.
REQ-018: Each ADD cycle SHALL drive rca_4bit with x = A[4*idx+3:4*idx], y = B[same], ci = carry register, and at the edge SHALL write s into sum nibble idx, load co into the carry register and increment idx.
REQ-019: After the edge that writes nibble NIBBLES-1 the FSM SHALL enter DONE, setting cout = final co and ovf = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]).
REQ-020: Latency SHALL be exactly NIBBLES cycles: with acceptance at edge T, out_valid rises after edge T+NIBBLES.
REQ-021: In DONE, sum, cout and ovf SHALL be held stable until out_valid && out_ready at an edge, which SHALL return the FSM to IDLE; with out_ready=0 the block SHALL hold indefinitely.
REQ-022: An operation is never accepted in the same cycle a result is released; back-to-back throughput SHALL be one operation per NIBBLES+2 cycles with out_ready held at 1.
REQ-023: Input changes on a, b, cin or in_valid outside IDLE SHALL have no effect on the operation in flight.
REQ-024: sum SHALL retain the previous result outside DONE; in ADD it updates nibble by nibble and its value is not valid until DONE.
REQ-025: idx SHALL never exceed NIBBLES-1; no wrap-around into a second pass is permitted.

Reset
REQ-026: rst=1 at an edge SHALL force the FSM to IDLE and clear sum, cout, ovf, idx, the carry register and the operand registers to 0, regardless of state.
REQ-027: While rst=1, in_ready and out_valid SHALL be 0.
REQ-028: Reset during ADD or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 on the first cycle after rst falls.
REQ-029: rst SHALL take priority over every simultaneous handshake.

Verification
REQ-030: Apply a=0x0007, b=0x0002, cin=0 (NIBBLES=4) -> after 4 cycles out_valid=1, sum=0x0009, cout=0, ovf=0.
REQ-031: Apply a=0x0696, b=0x0969, cin=1 -> sum=0x1000, cout=0, ovf=0, exercising carry propagation across three nibbles; a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
REQ-032: Apply a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-033: Hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> sum and out_valid remain stable and in_ready stays 0; when out_ready=1 the result releases and in_ready=1 on the next cycle.
REQ-034: Assert rst for one cycle during the second ADD cycle -> no out_valid, all outputs 0, in_ready=1 next cycle; a new a=0x0003, b=0x0005, cin=1 then yields sum=0x0009.
REQ-035: Issue three back-to-back operations with in_valid and out_ready held at 1 -> acceptances are exactly 6 cycles apart and each result matches a+b+cin against a reference model.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder that reuses one 4-bit ripple-carry stage, one nibble per cycle,
// with valid/ready handshakes on the operand and result sides.
module rca_4bit (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   assign co   = c[4];
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state, state_n;
   logic [W-1:0] op_a, op_b;
   logic [IW-1:0] idx;
   logic carry, co;
   logic [3:0] nib_a, nib_b, s;
   assign nib_a     = op_a[{idx, 2'b00} +: 4];
   assign nib_b     = op_b[{idx, 2'b00} +: 4];
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE) && !rst;
   rca_4bit u_rca (.x(nib_a), .y(nib_b), .ci(carry), .s(s), .co(co));
   always_comb begin
      state_n = state;
      if (state == IDLE && in_valid) state_n = ADD;
      if (state == ADD && idx == LAST) state_n = DONE;
      if (state == DONE && out_ready) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
         end
         if (state == ADD) begin
            sum[{idx, 2'b00} +: 4] <= s;
            carry <= co;
            // idx parks on the last nibble rather than wrapping into a second pass
            if (idx != LAST) idx <= idx + 1'b1;
            else begin
               cout <= co;
               ovf  <= (op_a[W-1] == op_b[W-1]) && (s[3] != op_a[W-1]);
            end
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomized checks of nibble_serial_adder
// against a plain-arithmetic reference model.
module tb_nibble_serial_adder;
   localparam int N = 4;
   localparam int W = 4 * N;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   // {ovf, cout, sum}
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] t;
      t = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
      return {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit hold);
      logic [W+1:0] r;
      int n;
      r = model(ta, tb, tc);
      n = 0;
      while (!in_ready && n < 20) begin step(); n++; end
      chk("ready_before_op", in_ready, 1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      chk("latency", n, N);
      chk("sum", sum, r[W-1:0]);
      chk("cout", cout, r[W]);
      chk("ovf", ovf, r[W+1]);
      if (!hold) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         chk("release_in_ready", in_ready, 1);
         chk("release_out_valid", out_valid, 0);
      end
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W+1:0] r;
      int acc[3];
      int n;
      bit seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_sum", sum, 0);
      chk("post_rst_cout", cout, 0);
      chk("post_rst_ovf", ovf, 0);

      run_op(16'h0007, 16'h0002, 1'b0, 0);
      run_op(16'h0696, 16'h0969, 1'b1, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h8000, 1'b0, 0);
      for (int i = 0; i < 8; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 0);

      // stall in DONE while the inputs churn
      run_op(16'h1234, 16'h4321, 1'b1, 1);
      held = sum;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
         step();
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_sum", sum, held);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("stall_release_in_ready", in_ready, 1);

      // reset in the second ADD cycle
      a = 16'h00F0; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      rst = 1'b0;
      #1;
      chk("abort_ready_after", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin step(); seen |= out_valid; end
      chk("abort_no_out_valid", seen, 0);
      run_op(16'h0003, 16'h0005, 1'b1, 0);

      // back-to-back with in_valid and out_ready held high
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         r = model(a, b, cin);
         n = 0;
         while (!in_ready && n < 20) begin step(); n++; end
         chk("b2b_ready", in_ready, 1);
         step();
         acc[k] = cyc;
         n = 0;
         while (!out_valid && n < 20) begin step(); n++; end
         chk("b2b_latency", n, N);
         chk("b2b_sum", sum, r[W-1:0]);
         chk("b2b_cout", cout, r[W]);
         chk("b2b_ovf", ovf, r[W+1]);
         if (k > 0) chk("b2b_spacing", acc[k] - acc[k-1], N + 2);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
